// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// A grant lasts up to BURSTLEN written words; every write is gated by f_full.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATAWIDTH = 8,
  parameter int BURSTLEN  = 4,
  parameter int IDXW      = 2
) (
  input  logic                      clk_wr,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATAWIDTH-1:0] req_data,
  input  logic                      f_full,
  output logic [NREQ-1:0]           req_ack,
  output logic                      fifo_wr_en,
  output logic [DATAWIDTH-1:0]      fifo_data,
  output logic                      grant_valid,
  output logic [IDXW-1:0]           grant_id,
  output logic                      burst_done
);

  // Handshake: requester i holds req[i] high and its req_data slice stable;
  // the word is consumed in exactly the cycle req_ack[i] is high, which is
  // always a cycle with fifo_wr_en high and f_full low.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  localparam logic [7:0]      LAST_CNT = 8'(BURSTLEN - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [7:0]      burst_cnt_q, burst_cnt_d;

  logic [DATAWIDTH-1:0] slice [NREQ];
  logic                 pick_found;
  logic [IDXW-1:0]      pick_idx;
  logic                 owner_req;
  logic                 wr_cyc;
  logic [IDXW-1:0]      owner_inc;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign slice[g] = req_data[g*DATAWIDTH +: DATAWIDTH];
  end

  assign owner_req = req[owner_q];
  // Explicit wrap so non-power-of-2 NREQ never yields an out-of-range index.
  assign owner_inc = (owner_q == LAST_IDX) ? '0 : owner_q + IDXW'(1);

  // First active requester at or after rr_ptr, circularly.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDXW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    req_ack     = '0;
    fifo_wr_en  = 1'b0;
    fifo_data   = '0;
    burst_done  = 1'b0;
    wr_cyc      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        fifo_data        = slice[owner_q];
        wr_cyc           = owner_req & ~f_full;
        fifo_wr_en       = wr_cyc;
        req_ack[owner_q] = wr_cyc;
        if (wr_cyc) burst_cnt_d = burst_cnt_q + 8'd1;
        if (!owner_req || (wr_cyc && burst_cnt_q == LAST_CNT)) begin
          burst_done = 1'b1;
          rr_ptr_d   = owner_inc;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // grant_valid is the FSM state made visible.
  assign grant_valid = (state_q == S_GRANT);
  assign grant_id    = grant_valid ? owner_q : '0;

  always_ff @(posedge clk_wr) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios then random traffic, checked
// against a transaction-level reference model through expected queues.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int BL   = 4;
  localparam int IW   = 2;
  localparam int WE   = 32 + IW + DW;      // {cycle, id, data} per write
  localparam int WG   = 32 + 1 + IW + DW;  // {cycle, valid, id, data} per cycle
  localparam int WR   = 32 + IW;           // {cycle, id} per release

  logic                 clk_wr = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_data;
  logic                 f_full;
  logic [NREQ-1:0]      req_ack;
  logic                 fifo_wr_en;
  logic [DW-1:0]        fifo_data;
  logic                 grant_valid;
  logic [IW-1:0]        grant_id;
  logic                 burst_done;

  logic [DW-1:0] tb_data [NREQ];

  // ---------------- clock / reset ----------------
  always #5 clk_wr = ~clk_wr;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = tb_data[i];
  end

  fifo_wr_arbiter #(.NREQ(NREQ), .DATAWIDTH(DW), .BURSTLEN(BL), .IDXW(IW)) dut (
    .clk_wr      (clk_wr),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .f_full      (f_full),
    .req_ack     (req_ack),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data   (fifo_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .burst_done  (burst_done)
  );

  // ---------------- scoreboard state ----------------
  logic [WE-1:0] exp_q[$];
  logic [WG-1:0] gnt_q[$];
  logic [WR-1:0] rel_q[$];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  bit mon_on = 1'b0;
  int wr_seen = 0;
  int ack_seen = 0;
  int model_writes = 0;
  bit rand_data = 1'b0;
  int pending_ack = -1;

  // Reference model: who owns the port, words written this grant, next priority.
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_words = 0;
  int m_ptr = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_cycle();
    bit wr;
    bit rel;
    int pick;
    logic [DW-1:0] d;
    d = m_busy ? tb_data[m_owner] : '0;
    gnt_q.push_back({32'(cyc), m_busy, IW'(m_busy ? m_owner : 0), d});
    wr  = m_busy && req[m_owner] && !f_full;
    rel = m_busy && (!req[m_owner] || (wr && (m_words + 1 == BL)));
    if (wr) begin
      exp_q.push_back({32'(cyc), IW'(m_owner), tb_data[m_owner]});
      model_writes++;
    end
    if (rel) rel_q.push_back({32'(cyc), IW'(m_owner)});
    pending_ack = wr ? m_owner : -1;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_words = 0; m_ptr = 0;
    end else if (!m_busy) begin
      pick = rr_pick(m_ptr, req);
      if (pick >= 0) begin
        m_busy = 1'b1; m_owner = pick; m_words = 0;
      end
    end else begin
      if (wr) m_words++;
      if (rel) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NREQ;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r_rst, input logic [NREQ-1:0] r_req, input bit r_full);
    @(posedge clk_wr);
    #1;
    cyc++;
    if (rand_data && pending_ack >= 0) tb_data[pending_ack] = DW'($urandom);
    rst    = r_rst;
    req    = r_req;
    f_full = r_full;
    model_cycle();
    mon_on = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk_wr);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic [WG-1:0]   g_e;
  logic [WE-1:0]   w_e;
  logic [WR-1:0]   r_e;
  logic [NREQ-1:0] oh;

  always @(negedge clk_wr) begin
    if (mon_on) begin
      if (gnt_q.size() > 0) begin
        g_e = gnt_q.pop_front();
        check("grant_valid", grant_valid, g_e[DW+IW]);
        check("grant_id", grant_id, g_e[DW+IW-1:DW]);
        check("fifo_data", fifo_data, g_e[DW-1:0]);
      end
      check("ack_popcount", $countones(req_ack), fifo_wr_en);
      if (fifo_wr_en) check("wr_en_while_full", f_full, 0);
      ack_seen += $countones(req_ack);

      if (fifo_wr_en) begin
        wr_seen++;
        if (exp_q.size() > 0 && int'(exp_q[0][WE-1 -: 32]) == cyc) begin
          w_e = exp_q.pop_front();
          oh = '0;
          oh[w_e[DW+IW-1:DW]] = 1'b1;
          check("wr_ack", req_ack, oh);
          check("wr_data", fifo_data, w_e[DW-1:0]);
        end else begin
          check("wr_en_unexpected", fifo_wr_en, 0);
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][WE-1 -: 32]) <= cyc) begin
        w_e = exp_q.pop_front();
        check("wr_en_missing", fifo_wr_en, 1);
      end

      if (burst_done) begin
        if (rel_q.size() > 0 && int'(rel_q[0][WR-1 -: 32]) == cyc) begin
          r_e = rel_q.pop_front();
          check("burst_done_id", grant_id, r_e[IW-1:0]);
        end else begin
          check("burst_done_unexpected", burst_done, 0);
        end
      end else if (rel_q.size() > 0 && int'(rel_q[0][WR-1 -: 32]) <= cyc) begin
        r_e = rel_q.pop_front();
        check("burst_done_missing", burst_done, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  int w0;

  initial begin
    rst = 1'b1; req = '0; f_full = 1'b0;
    tb_data[0] = 8'h11; tb_data[1] = 8'h22; tb_data[2] = 8'h33; tb_data[3] = 8'h44;
    step(1, '0, 0);
    step(1, '0, 0);

    // Single requester: idle, 4 writes, idle, re-grant.
    repeat (12) step(0, 4'b0001, 0);

    // Round-robin with everyone requesting: 24 writes in 30 cycles.
    step(1, '0, 0);
    settle();
    w0 = wr_seen;
    repeat (30) step(0, 4'b1111, 0);
    settle();
    check("rr_writes_in_30", wr_seen - w0, 24);

    // Full stall on requester 2 after its second write.
    step(1, '0, 0);
    settle();
    w0 = wr_seen;
    repeat (3) step(0, 4'b0100, 0);
    repeat (5) step(0, 4'b0100, 1);
    repeat (2) step(0, 4'b0100, 0);
    settle();
    check("stall_writes", wr_seen - w0, 4);
    repeat (2) step(0, '0, 0);

    // Early release: requester 1 drops after 2 acks, requester 3 waiting.
    step(1, '0, 0);
    repeat (3) step(0, 4'b1010, 0);
    repeat (6) step(0, 4'b1000, 0);

    // Reset mid-burst.
    step(1, '0, 0);
    repeat (2) step(0, 4'b1111, 0);
    step(1, 4'b1111, 0);
    repeat (8) step(0, 4'b1111, 0);

    // Random traffic with data refreshed only after each ack.
    rand_data = 1'b1;
    repeat (3000) begin
      step($urandom_range(0, 199) == 0, NREQ'($urandom_range(0, 15)),
           $urandom_range(0, 4) == 0);
    end

    repeat (3) step(0, '0, 0);
    settle();
    check("leftover_writes", exp_q.size(), 0);
    check("leftover_releases", rel_q.size(), 0);
    check("total_writes", wr_seen, model_writes);
    check("acks_vs_wr_en", ack_seen, wr_seen);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one async FIFO write port among NREQ requesters in the write clock domain.
- Grants one requester at a time for a bounded burst of up to BURSTLEN words.
- Gates every write on the FIFO full flag, so a requester's ack matches a real FIFO write exactly.
- Sits between the producer blocks and the FIFO's wr_en / data_in / f_full pins.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DATAWIDTH, 8, FIFO data width.
- BURSTLEN, 4, maximum words written per grant (1..255).
- IDXW, 2, width of the requester index; must equal ceil(log2(NREQ)).

Ports:
- clk_wr  in  1  FIFO write clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  NREQ  per-requester write request; a requester holds it high while it has a word to send.
- req_data  in  NREQ*DATAWIDTH  requester i's word on bits [i*DATAWIDTH +: DATAWIDTH]; held stable until acked.
- f_full  in  1  FIFO full flag (write-domain view).
- req_ack  out  NREQ  one-hot; bit i high means requester i's word is written this cycle.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_data  out  DATAWIDTH  to FIFO data_in.
- grant_valid  out  1  high while in GRANT.
- grant_id  out  IDXW  current owner; only meaningful when grant_valid is high.
- burst_done  out  1  single-cycle pulse in the cycle a grant is released.

Behaviour:
- Reset: on a clk_wr edge with rst=1, all state clears.
  - state=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
  - All outputs are 0 in the following cycle.
  - A reset mid-burst abandons the burst with no further writes or acks. Requesters keep req high and re-arbitrate afterwards.
- State machine: two states, IDLE and GRANT.
- IDLE:
  - fifo_wr_en=0, req_ack=0.
  - If any req bit is high, owner := the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - On that grant: burst_cnt:=0, next state GRANT.
  - Arbitration latency is 1 cycle: no write happens in the IDLE cycle.
- GRANT:
  - wr_cyc = req[owner] & !f_full.
  - fifo_wr_en = wr_cyc and req_ack[owner] = wr_cyc; both are combinational from registered owner/state and the live inputs.
  - fifo_data = req_data slice of owner, driven every GRANT cycle; 0 in IDLE.
  - On a wr_cyc cycle: burst_cnt := burst_cnt+1.
- Release: the grant is released (next state IDLE, burst_done=1 that cycle, rr_ptr := owner+1 mod NREQ) when either:
  - (a) wr_cyc and burst_cnt==BURSTLEN-1, i.e. the last word of the burst is written this cycle; or
  - (b) req[owner]==0. No write occurs in that cycle.
- f_full stall:
  - In GRANT with f_full=1 and req[owner]=1: no write, no ack, burst_cnt holds, grant holds indefinitely.
  - If req[owner] drops while f_full is high, rule (b) applies: release.
- Simultaneous events: a non-owner req is ignored until release. The rotated rr_ptr guarantees the releasing requester has lowest priority in the next IDLE cycle, so there is no starvation.
- Widths and wrap-around:
  - burst_cnt is 8 bits.
  - rr_ptr and owner are IDXW bits and wrap at NREQ (explicit compare, not natural overflow when NREQ is not a power of 2).
- Invariants:
  - req_ack is zero or one-hot.
  - popcount(req_ack)==fifo_wr_en at all times.
  - fifo_wr_en is never high while f_full is high.

Test Plan:
- Reset then single requester: req=4'b0001, req_data[0]=8'h11 held, f_full=0.
  - Response: IDLE for 1 cycle, then 4 consecutive acks on bit 0 with fifo_data=8'h11.
  - burst_done on the 4th ack; IDLE for 1 cycle; then re-grant to requester 0 (only requester).
- Round-robin fairness: req=4'b1111 held for 30 cycles.
  - Response: grant_id sequence 0,1,2,3,0,...; each grant yields exactly 4 writes.
  - 24 writes in 30 cycles; fifo_data matches the owner's slice every write.
- Full stall: requester 2 granted; f_full=1 asserted after its 2nd write for 5 cycles.
  - Response: fifo_wr_en=0 and req_ack=0 for those 5 cycles; grant_valid stays 1, grant_id=2.
  - After f_full drops, exactly 2 more writes, then burst_done.
- Early release: requester 1 drops req after 2 acks while req[3]=1.
  - Response: burst_done in the cycle req[1] is seen low, no write that cycle, next grant_id=3.
- Reset mid-burst: rst=1 for 1 cycle after the 1st write of a burst.
  - Response: next cycle all outputs 0, state IDLE, rr_ptr=0.
  - Lowest-index active requester is granted afterwards.
- Invariant checks for the whole run:
  - Every ack coincides with a FIFO write and f_full=0.
  - Total acks equal total fifo_wr_en cycles.
